// File: rtl/addr_window_clip.sv
// Per-channel clip-window classifier with a two-stage pass/flag/drop pipeline
// and a saturating drop counter per channel.
module addr_window_clip #(
  parameter int XW   = 16,
  parameter int WW   = 15,
  parameter int NCH  = 2,
  parameter int CNTW = 16,
  parameter int CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic            sys_clk,
  input  logic            reset,
  input  logic            win_load,
  input  logic [CHW-1:0]  win_ch,
  input  logic [WW-1:0]   win_x,
  input  logic [WW-1:0]   win_y,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [CHW-1:0]  in_ch,
  input  logic [XW-1:0]   in_x,
  input  logic [XW-1:0]   in_y,
  input  logic [1:0]      in_mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CHW-1:0]  out_ch,
  output logic [XW-1:0]   out_x,
  output logic [XW-1:0]   out_y,
  output logic            out_outside,
  input  logic [CHW-1:0]  cnt_sel,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] cnt_val
);

  localparam logic [1:0] MODE_DROP_OUT = 2'b01;
  localparam logic [1:0] MODE_DROP_IN  = 2'b10;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; a producer holding valid keeps its payload stable until that edge.

  logic [WW-1:0]   win_x_q [NCH];
  logic [WW-1:0]   win_x_d [NCH];
  logic [WW-1:0]   win_y_q [NCH];
  logic [WW-1:0]   win_y_d [NCH];
  logic [CNTW-1:0] cnt_q   [NCH];
  logic [CNTW-1:0] cnt_d   [NCH];

  logic            s1_v_q, s1_v_d;
  logic [CHW-1:0]  s1_ch_q, s1_ch_d;
  logic [XW-1:0]   s1_x_q, s1_x_d;
  logic [XW-1:0]   s1_y_q, s1_y_d;
  logic [1:0]      s1_mode_q, s1_mode_d;
  logic            s1_out_q, s1_out_d;

  logic            s2_v_q, s2_v_d;
  logic [CHW-1:0]  s2_ch_q, s2_ch_d;
  logic [XW-1:0]   s2_x_q, s2_x_d;
  logic [XW-1:0]   s2_y_q, s2_y_d;
  logic            s2_out_q, s2_out_d;

  logic            accept;
  logic            s1_drop;
  logic            s2_load;
  logic            s1_move;
  logic            in_outside;

  // Signed compare one bit wider than XW so a full-range window never truncates.
  function automatic logic is_outside(input logic [XW-1:0] x, input logic [XW-1:0] y,
                                      input logic [WW-1:0] wx, input logic [WW-1:0] wy);
    logic signed [XW:0] xs, ys, wxs, wys;
    xs  = {x[XW-1], x};
    ys  = {y[XW-1], y};
    wxs = {{(XW + 1 - WW){1'b0}}, wx};
    wys = {{(XW + 1 - WW){1'b0}}, wy};
    return x[XW-1] || y[XW-1] || (xs >= wxs) || (ys >= wys);
  endfunction

  assign in_outside = is_outside(in_x, in_y, win_x_q[in_ch], win_y_q[in_ch]);
  assign s1_drop    = s1_v_q && (((s1_mode_q == MODE_DROP_OUT) && s1_out_q) ||
                                 ((s1_mode_q == MODE_DROP_IN) && !s1_out_q));
  assign s2_load    = !s2_v_q || out_ready;
  assign s1_move    = s1_v_q && (s1_drop || s2_load);
  assign in_ready   = !reset && (!s1_v_q || s1_move);
  assign accept     = in_valid && in_ready;

  assign out_valid   = s2_v_q;
  assign out_ch      = s2_ch_q;
  assign out_x       = s2_x_q;
  assign out_y       = s2_y_q;
  assign out_outside = s2_out_q;
  assign cnt_val     = cnt_q[cnt_sel];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      win_x_d[i] = win_x_q[i];
      win_y_d[i] = win_y_q[i];
      if (win_load && (win_ch == CHW'(i))) begin
        win_x_d[i] = win_x;
        win_y_d[i] = win_y;
      end
    end
  end

  // Clear has priority over a drop landing on the same channel in the same cycle.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_clr && (cnt_sel == CHW'(i))) begin
        cnt_d[i] = '0;
      end else if (s1_drop && (s1_ch_q == CHW'(i)) && (cnt_q[i] != {CNTW{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNTW'(1);
      end
    end
  end

  always_comb begin
    s1_v_d    = s1_v_q;
    s1_ch_d   = s1_ch_q;
    s1_x_d    = s1_x_q;
    s1_y_d    = s1_y_q;
    s1_mode_d = s1_mode_q;
    s1_out_d  = s1_out_q;
    if (accept) begin
      s1_v_d    = 1'b1;
      s1_ch_d   = in_ch;
      s1_x_d    = in_x;
      s1_y_d    = in_y;
      s1_mode_d = in_mode;
      s1_out_d  = in_outside;
    end else if (s1_move) begin
      s1_v_d    = 1'b0;
    end
  end

  // S2 payload only changes when it can be replaced, so a stalled output holds.
  always_comb begin
    s2_v_d   = s2_v_q;
    s2_ch_d  = s2_ch_q;
    s2_x_d   = s2_x_q;
    s2_y_d   = s2_y_q;
    s2_out_d = s2_out_q;
    if (s2_load) begin
      s2_v_d = s1_v_q && !s1_drop;
      if (s1_v_q && !s1_drop) begin
        s2_ch_d  = s1_ch_q;
        s2_x_d   = s1_x_q;
        s2_y_d   = s1_y_q;
        s2_out_d = s1_out_q;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        win_x_q[i] <= '0;
        win_y_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
      s1_v_q    <= 1'b0;
      s1_ch_q   <= '0;
      s1_x_q    <= '0;
      s1_y_q    <= '0;
      s1_mode_q <= '0;
      s1_out_q  <= 1'b0;
      s2_v_q    <= 1'b0;
      s2_ch_q   <= '0;
      s2_x_q    <= '0;
      s2_y_q    <= '0;
      s2_out_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        win_x_q[i] <= win_x_d[i];
        win_y_q[i] <= win_y_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      s1_v_q    <= s1_v_d;
      s1_ch_q   <= s1_ch_d;
      s1_x_q    <= s1_x_d;
      s1_y_q    <= s1_y_d;
      s1_mode_q <= s1_mode_d;
      s1_out_q  <= s1_out_d;
      s2_v_q    <= s2_v_d;
      s2_ch_q   <= s2_ch_d;
      s2_x_q    <= s2_x_d;
      s2_y_q    <= s2_y_d;
      s2_out_q  <= s2_out_d;
    end
  end

endmodule

// File: tb/tb_addr_window_clip.sv
// Directed-vector bench for addr_window_clip: drivers push expected outputs into
// a queue, a negedge monitor pops and compares every accepted output.
module tb_addr_window_clip;

  localparam int XW   = 16;
  localparam int WW   = 15;
  localparam int NCH  = 2;
  localparam int CNTW = 2;
  localparam int CHW  = 1;
  localparam int W    = CHW + 2 * XW + 1;

  logic            clk;
  logic            reset;
  logic            win_load;
  logic [CHW-1:0]  win_ch;
  logic [WW-1:0]   win_x;
  logic [WW-1:0]   win_y;
  logic            in_valid;
  logic            in_ready;
  logic [CHW-1:0]  in_ch;
  logic [XW-1:0]   in_x;
  logic [XW-1:0]   in_y;
  logic [1:0]      in_mode;
  logic            out_valid;
  logic            out_ready;
  logic [CHW-1:0]  out_ch;
  logic [XW-1:0]   out_x;
  logic [XW-1:0]   out_y;
  logic            out_outside;
  logic [CHW-1:0]  cnt_sel;
  logic            cnt_clr;
  logic [CNTW-1:0] cnt_val;

  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_miss = 0;

  addr_window_clip #(.XW(XW), .WW(WW), .NCH(NCH), .CNTW(CNTW)) dut (
    .sys_clk(clk), .reset(reset),
    .win_load(win_load), .win_ch(win_ch), .win_x(win_x), .win_y(win_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
    .in_x(in_x), .in_y(in_y), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_x(out_x), .out_y(out_y), .out_outside(out_outside),
    .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_val(cnt_val)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL out_unexpected got ch=%0d x=%0d y=%0d outside=%0d",
                 out_ch, $signed(out_x), $signed(out_y), out_outside);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if ({out_ch, out_x, out_y, out_outside} !== e) begin
          n_miss++;
          $display("FAIL out_item got ch=%0d x=%0d y=%0d outside=%0d exp ch=%0d x=%0d y=%0d outside=%0d",
                   out_ch, $signed(out_x), $signed(out_y), out_outside,
                   e[W-1 -: CHW], $signed(e[2*XW:XW+1]), $signed(e[XW:1]), e[0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Driver tasks: all start and end at posedge+1
  task automatic send(input logic [CHW-1:0] ch, input int x, input int y,
                      input logic [1:0] mode, input logic exp_out, input logic pass);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_ch    = ch;
    in_x     = XW'(x);
    in_y     = XW'(y);
    in_mode  = mode;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_miss++;
      $display("FAIL send_timeout got in_ready=0 exp 1 x=%0d y=%0d", x, y);
    end else if (pass) begin
      exp_q.push_back({ch, XW'(x), XW'(y), exp_out});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic load_win(input logic [CHW-1:0] ch, input int wx, input int wy);
    win_load = 1'b1;
    win_ch   = ch;
    win_x    = WW'(wx);
    win_y    = WW'(wy);
    @(posedge clk);
    #1;
    win_load = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain_timeout got pending=%0d exp 0", exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input logic [CHW-1:0] sel, input int exp, input string name);
    cnt_sel = sel;
    @(negedge clk);
    check(name, 32'(cnt_val), exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; win_load = 1'b0; win_ch = '0; win_x = '0; win_y = '0;
    in_valid = 1'b0; in_ch = '0; in_x = '0; in_y = '0; in_mode = '0;
    out_ready = 1'b1; cnt_sel = '0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_cnt", 32'(cnt_val), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: classification edges, mode 00
    load_win(1'b0, 320, 200);
    send(1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
    send(1'b0, 319, 199, 2'b00, 1'b0, 1'b1);
    send(1'b0, 320, 0, 2'b00, 1'b1, 1'b1);
    send(1'b0, -1, 5, 2'b00, 1'b1, 1'b1);
    send(1'b0, 0, 200, 2'b00, 1'b1, 1'b1);
    drain();

    // 2: drop-outside stream on ch1
    load_win(1'b1, 16, 16);
    send(1'b1, 0, 0, 2'b01, 1'b0, 1'b1);
    send(1'b1, 15, 15, 2'b01, 1'b0, 1'b1);
    send(1'b1, 16, 0, 2'b01, 1'b0, 1'b0);
    send(1'b1, 3, 4, 2'b01, 1'b0, 1'b1);
    send(1'b1, -2, 1, 2'b01, 1'b0, 1'b0);
    send(1'b1, 7, 7, 2'b01, 1'b0, 1'b1);
    send(1'b1, 0, 16, 2'b01, 1'b0, 1'b0);
    send(1'b1, 15, 0, 2'b01, 1'b0, 1'b1);
    drain();
    check_cnt(1'b1, 3, "cnt_ch1_after_stream");
    check_cnt(1'b0, 0, "cnt_ch0_after_stream");

    // drop-inside mode: inside dropped, outside passed and flagged
    send(1'b0, 1, 1, 2'b10, 1'b0, 1'b0);
    send(1'b0, 330, 2, 2'b10, 1'b1, 1'b1);
    drain();
    check_cnt(1'b0, 1, "cnt_ch0_mode10");

    // 3: stall with both stages full
    out_ready = 1'b0;
    send(1'b0, 5, 5, 2'b11, 1'b0, 1'b1);
    send(1'b0, 400, 1, 2'b11, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_in_ready", 32'(in_ready), 0);
      check("stall_out_valid", 32'(out_valid), 1);
      check("stall_out_x", 32'(out_x), 5);
      check("stall_out_y", 32'(out_y), 5);
      check("stall_out_outside", 32'(out_outside), 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(1'b0, -3, 7, 2'b11, 1'b1, 1'b1);
    drain();

    // 4: window load on the same edge as an accept uses the old window
    win_load = 1'b1;
    win_ch   = 1'b0;
    win_x    = WW'(8);
    win_y    = WW'(8);
    send(1'b0, 10, 2, 2'b00, 1'b0, 1'b1);
    win_load = 1'b0;
    send(1'b0, 10, 2, 2'b00, 1'b1, 1'b1);
    drain();

    // 5: saturation at 3 and clear beating a same-cycle drop
    cnt_sel = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_cnt(1'b1, 0, "cnt_ch1_cleared");
    for (int i = 0; i < 5; i++) send(1'b1, 20, 0, 2'b01, 1'b0, 1'b0);
    drain();
    check_cnt(1'b1, 3, "cnt_ch1_saturated");
    send(1'b1, 20, 0, 2'b01, 1'b0, 1'b0);
    cnt_sel = 1'b1;
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    check_cnt(1'b1, 0, "cnt_clr_wins_drop");
    send(1'b1, 20, 0, 2'b01, 1'b0, 1'b0);
    drain();
    check_cnt(1'b1, 1, "cnt_after_clr_drop");

    // 6: reset with both stages valid
    out_ready = 1'b0;
    send(1'b0, 1, 1, 2'b00, 1'b0, 1'b1);
    send(1'b0, 2, 2, 2'b00, 1'b0, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("postrst_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    check_cnt(1'b0, 0, "postrst_cnt_ch0");
    check_cnt(1'b1, 0, "postrst_cnt_ch1");
    out_ready = 1'b1;
    send(1'b0, 0, 0, 2'b00, 1'b1, 1'b1);
    send(1'b1, 0, 0, 2'b00, 1'b1, 1'b1);
    send(1'b0, 3, 3, 2'b11, 1'b1, 1'b1);
    drain();

    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
